ula_issue: RTL and testbench
============================

// Module: ula_issue
// PURPOSE
//  Issue stage directly upstream of the 8-bit ALU (SrcA/SrcB/ULAControl consumer).
//  - Accepts decoded ops from decode: rs1/rs2 values, immediate, ALUOp, funct3, funct7b5, op5, ALUSrc.
//  - Decodes the 3-bit ALU control code and selects operand B (rs2 or imm).
//  - Buffers up to 2 issued ops in a skid FIFO with valid/ready handshakes on both sides.
//  - Head entry drives the ALU inputs from registers.
// PARAMETERS
//  WIDTH  8  datapath width of rs1/rs2/imm/SrcA/SrcB
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  flush       in   1      sync discard of all buffered ops (branch redirect)
//  in_valid    in   1      decode presents an op
//  in_ready    out  1      stage can accept an op this cycle
//  rs1_val     in   WIDTH  operand A source
//  rs2_val     in   WIDTH  operand B source when alu_src=0
//  imm_val     in   WIDTH  operand B source when alu_src=1
//  alu_src     in   1      0: B=rs2_val, 1: B=imm_val
//  alu_op      in   2      00 add, 01 sub, 10 funct-decoded, 11 illegal
//  funct3      in   3      instruction funct3
//  funct7b5    in   1      instruction bit 30
//  op5         in   1      instruction bit 5 (1 = R-type)
//  out_valid   out  1      head entry valid toward ALU
//  out_ready   in   1      ALU/execute consumes head this cycle
//  SrcA        out  WIDTH  head operand A
//  SrcB        out  WIDTH  head operand B
//  ULAControl  out  3      head ALU control code
//  illegal     out  1      head op has no legal ALU code (qualified by out_valid)
// BEHAVIOUR
//  - Reset (async): FIFO count=0, pointers=0.
//    in_ready=1, out_valid=0, SrcA=SrcB=0, ULAControl=3'b000, illegal=0.
//  - Decode is combinational on input; the result is stored with the entry.
//    - alu_op 00 -> 000 (add); alu_op 01 -> 001 (sub).
//    - alu_op 10, funct3:
//      - 000: 001 if {op5,funct7b5}==2'b11, else 000.
//      - 010 -> 101; 100 -> 100; 110 -> 011; 111 -> 010.
//      - 001/011/101 -> code 000, illegal=1.
//    - alu_op 11 -> 000, illegal=1. Illegal ops are still buffered and issued, not dropped.
//  - in_ready = (count<2), registered-derived only. in_ready never depends combinationally on out_ready.
//  - push = in_valid & in_ready & ~flush.
//  - pop  = out_valid & out_ready & ~flush.
//  - out_valid = (count>0). Outputs show the head entry. Non-head outputs hold their last value (no X).
//  - Latency: op pushed at edge N appears at the outputs with out_valid=1 after edge N. Zero bubbles.
//  - count=0 and push: count becomes 1.
//  - count=1 and push+pop: count stays 1; the new op becomes head after the edge.
//  - count=2 (full): in_ready=0; pop frees a slot, visible the next cycle.
//  - Pointers wrap modulo 2. Order is strictly FIFO.
//  - flush: count=0 and pointers=0 at the next edge. Wins over a same-cycle push/pop; neither takes effect.
//  - Stall: while out_valid & ~out_ready, SrcA/SrcB/ULAControl/illegal hold stable.
//  - Reset mid-operation discards all entries immediately (async). No partial state survives.
//  - Operands are stored unmodified; no arithmetic here. Width is exactly WIDTH, no truncation.
// TESTING
//  1. Reset, then in_valid: rs1=8'h05, rs2=8'h03, alu_op=00, alu_src=0, out_ready=1.
//     -> next cycle out_valid=1, SrcA=05, SrcB=03, ULAControl=000.
//  2. R-type sub (alu_op=10, f3=000, op5=1, f7b5=1), then I-type addi (op5=0, f7b5=1, alu_src=1, imm=8'hFF).
//     -> codes 001 then 000; SrcB=FF on the second op.
//  3. Funct3 sweep 010/100/110/111/001 under alu_op=10.
//     -> 101/100/011/010/000; illegal=1 only for 001.
//  4. out_ready=0, push ops A, B, C back-to-back.
//     -> in_ready drops after B; C held off; outputs stable at A.
//     Then raise out_ready -> A, B, C delivered in order with no loss.
//  5. count=2 with flush=1 and in_valid=1 in the same cycle.
//     -> next cycle out_valid=0, in_ready=1; the pushed op is not stored.
//  6. Assert reset asynchronously between edges with count=1.
//     -> out_valid=0 and SrcA=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/ula_issue_if.sv
// Handshake and operand bundle between decode, the ALU issue stage and the ALU.
// Decode/ALU side drives through master; the issue stage sits on slave.
interface ula_issue_if #(
    parameter int unsigned WIDTH = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] imm_val;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             op5;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ULAControl;
    logic             illegal;

    modport master (
        output flush, in_valid, rs1_val, rs2_val, imm_val, alu_src, alu_op, funct3, funct7b5,
               op5, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, ULAControl, illegal
    );

    modport slave (
        input  flush, in_valid, rs1_val, rs2_val, imm_val, alu_src, alu_op, funct3, funct7b5,
               op5, out_ready,
        output in_ready, out_valid, SrcA, SrcB, ULAControl, illegal
    );
endinterface

// File: rtl/ula_issue.sv
// ALU issue stage: decodes the ALU control code, selects operand B and buffers up to two
// ops in a skid FIFO whose head drives the ALU from registers.
module ula_issue #(
    parameter int unsigned WIDTH = 8
) (
    input logic       clk,
    input logic       reset,
    ula_issue_if.slave bus_io
);
    logic [WIDTH-1:0] a_q    [2];
    logic [WIDTH-1:0] b_q    [2];
    logic [2:0]       ctrl_q [2];
    logic             ill_q  [2];
    logic             wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] src_a_q, src_b_q;
    logic [2:0]       ula_ctrl_q;
    logic             illegal_q;

    logic             push, pop, head_from_in;
    logic [2:0]       dec_ctrl;
    logic             dec_ill;
    logic [WIDTH-1:0] op_b;

    assign bus_io.in_ready   = (count_q != 2'd2);
    assign bus_io.out_valid  = (count_q != 2'd0);
    assign bus_io.SrcA       = src_a_q;
    assign bus_io.SrcB       = src_b_q;
    assign bus_io.ULAControl = ula_ctrl_q;
    assign bus_io.illegal    = illegal_q;

    assign push = bus_io.in_valid & bus_io.in_ready & ~bus_io.flush;
    assign pop  = bus_io.out_valid & bus_io.out_ready & ~bus_io.flush;
    assign op_b = bus_io.alu_src ? bus_io.imm_val : bus_io.rs2_val;

    always_comb begin
        dec_ctrl = 3'b000;
        dec_ill  = 1'b0;
        unique case (bus_io.alu_op)
            2'b00: dec_ctrl = 3'b000;
            2'b01: dec_ctrl = 3'b001;
            2'b10: begin
                unique case (bus_io.funct3)
                    3'b000:  dec_ctrl = ({bus_io.op5, bus_io.funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  dec_ctrl = 3'b101;
                    3'b100:  dec_ctrl = 3'b100;
                    3'b110:  dec_ctrl = 3'b011;
                    3'b111:  dec_ctrl = 3'b010;
                    default: dec_ill  = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (bus_io.flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
        end
        // The incoming op becomes head when it lands in the slot the read pointer moves to.
        head_from_in = push && (wr_ptr_q == rd_ptr_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q[0]     <= '0;
            a_q[1]     <= '0;
            b_q[0]     <= '0;
            b_q[1]     <= '0;
            ctrl_q[0]  <= 3'b000;
            ctrl_q[1]  <= 3'b000;
            ill_q[0]   <= 1'b0;
            ill_q[1]   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            ula_ctrl_q <= 3'b000;
            illegal_q  <= 1'b0;
        end else begin
            if (push) begin
                a_q[wr_ptr_q]    <= bus_io.rs1_val;
                b_q[wr_ptr_q]    <= op_b;
                ctrl_q[wr_ptr_q] <= dec_ctrl;
                ill_q[wr_ptr_q]  <= dec_ill;
            end
            wr_ptr_q <= bus_io.flush ? 1'b0 : (wr_ptr_q ^ push);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Head registers only change when an entry will be valid; otherwise hold.
            if (count_d != 2'd0) begin
                if (head_from_in) begin
                    src_a_q    <= bus_io.rs1_val;
                    src_b_q    <= op_b;
                    ula_ctrl_q <= dec_ctrl;
                    illegal_q  <= dec_ill;
                end else begin
                    src_a_q    <= a_q[rd_ptr_d];
                    src_b_q    <= b_q[rd_ptr_d];
                    ula_ctrl_q <= ctrl_q[rd_ptr_d];
                    illegal_q  <= ill_q[rd_ptr_d];
                end
            end
        end
    end
endmodule

// File: tb/tb_ula_issue.sv
// Directed self-checking bench for ula_issue with hand-computed expectations.
module tb_ula_issue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ula_issue_if #(.WIDTH(8)) bus ();
    ula_issue #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus_io(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] imm, input logic src, input logic [1:0] op,
                         input logic [2:0] f3, input logic f7, input logic o5);
        bus.in_valid = v;
        bus.rs1_val  = a;
        bus.rs2_val  = b;
        bus.imm_val  = imm;
        bus.alu_src  = src;
        bus.alu_op   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.op5      = o5;
    endtask

    logic [2:0] sweep_f3  [5] = '{3'b010, 3'b100, 3'b110, 3'b111, 3'b001};
    logic [2:0] sweep_exp [5] = '{3'b101, 3'b100, 3'b011, 3'b010, 3'b000};
    logic       sweep_ill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_srca", 32'(bus.SrcA), 32'h0);
        chk("rst_srcb", 32'(bus.SrcB), 32'h0);
        chk("rst_ctrl", 32'(bus.ULAControl), 32'h0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        reset = 1'b0;
        step();

        // 1: simple add
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h05, 8'h03, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_srca", 32'(bus.SrcA), 32'h05);
        chk("t1_srcb", 32'(bus.SrcB), 32'h03);
        chk("t1_ctrl", 32'(bus.ULAControl), 32'h0);

        // 2: R-type sub then addi with imm
        drive(1'b1, 8'h10, 8'h20, 8'h99, 1'b0, 2'b10, 3'b000, 1'b1, 1'b1);
        step();
        chk("t2_sub_ctrl", 32'(bus.ULAControl), 32'h1);
        chk("t2_sub_srcb", 32'(bus.SrcB), 32'h20);
        drive(1'b1, 8'h11, 8'h77, 8'hFF, 1'b1, 2'b10, 3'b000, 1'b1, 1'b0);
        step();
        chk("t2_addi_ctrl", 32'(bus.ULAControl), 32'h0);
        chk("t2_addi_srcb", 32'(bus.SrcB), 32'hFF);
        chk("t2_addi_srca", 32'(bus.SrcA), 32'h11);

        // 3: funct3 sweep plus alu_op 01 and 11
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h30 + i), 8'h01, 8'h00, 1'b0, 2'b10, sweep_f3[i], 1'b0, 1'b1);
            step();
            chk("t3_ctrl", 32'(bus.ULAControl), 32'(sweep_exp[i]));
            chk("t3_illegal", 32'(bus.illegal), 32'(sweep_ill[i]));
        end
        drive(1'b1, 8'h40, 8'h02, 8'h00, 1'b0, 2'b01, 3'b111, 1'b0, 1'b0);
        step();
        chk("t3_op01_ctrl", 32'(bus.ULAControl), 32'h1);
        chk("t3_op01_ill", 32'(bus.illegal), 32'd0);
        drive(1'b1, 8'h41, 8'h02, 8'h00, 1'b0, 2'b11, 3'b010, 1'b0, 1'b0);
        step();
        chk("t3_op11_ctrl", 32'(bus.ULAControl), 32'h0);
        chk("t3_op11_ill", 32'(bus.illegal), 32'd1);
        chk("t3_op11_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        step();
        chk("t3_drain", 32'(bus.out_valid), 32'd0);

        // 4: back-pressure with A, B, C
        bus.out_ready = 1'b0;
        drive(1'b1, 8'hA1, 8'hA2, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        chk("t4_a_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_a_srca", 32'(bus.SrcA), 32'hA1);
        drive(1'b1, 8'hB1, 8'hB2, 8'h00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0);
        step();
        chk("t4_full_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_stall_srca", 32'(bus.SrcA), 32'hA1);
        drive(1'b1, 8'hC1, 8'hC2, 8'hC3, 1'b1, 2'b10, 3'b110, 1'b0, 1'b0);
        step();
        chk("t4_held_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_held_srca", 32'(bus.SrcA), 32'hA1);
        chk("t4_held_srcb", 32'(bus.SrcB), 32'hA2);
        chk("t4_held_ctrl", 32'(bus.ULAControl), 32'h0);
        bus.out_ready = 1'b1;
        step();
        chk("t4_b_srca", 32'(bus.SrcA), 32'hB1);
        chk("t4_b_ctrl", 32'(bus.ULAControl), 32'h1);
        chk("t4_b_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("t4_c_srca", 32'(bus.SrcA), 32'hC1);
        chk("t4_c_srcb", 32'(bus.SrcB), 32'hC3);
        chk("t4_c_ctrl", 32'(bus.ULAControl), 32'h3);
        bus.in_valid = 1'b0;
        step();
        chk("t4_empty", 32'(bus.out_valid), 32'd0);
        chk("t4_empty_ready", 32'(bus.in_ready), 32'd1);

        // 5: flush while full with a push attempt
        bus.out_ready = 1'b0;
        drive(1'b1, 8'hD1, 8'hD2, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hE1, 8'hE2, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        chk("t5_full", 32'(bus.in_ready), 32'd0);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'hF1, 8'hF2, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        chk("t5_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_flush_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_hold_srca", 32'(bus.SrcA), 32'hD1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("t5_not_stored", 32'(bus.out_valid), 32'd0);

        // 6: async reset mid-cycle with one entry
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h5A, 8'h5B, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_pre_srca", 32'(bus.SrcA), 32'h5A);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_async_srca", 32'(bus.SrcA), 32'h0);
        chk("t6_async_ready", 32'(bus.in_ready), 32'd1);
        #4;
        reset = 1'b0;
        step();
        chk("t6_after_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
